// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor slice: counter encoding, controller FSM states,
// update FIFO entry and the saturating counter update.
package bp_pkg;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned PC_W  = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t STRONG_NT = 2'b00;
    localparam cnt_t WEAK_NT   = 2'b01;
    localparam cnt_t WEAK_T    = 2'b10;
    localparam cnt_t STRONG_T  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WRITE
    } state_t;

    // Default-width FIFO entry; the controller re-declares it at its own AWIDTH.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } entry_t;

    function automatic cnt_t sat_update(input logic hit, input cnt_t cnt, input logic taken);
        cnt_t nxt;
        if (!hit)
            nxt = taken ? WEAK_T : WEAK_NT;
        else if (taken)
            nxt = (cnt == STRONG_T) ? STRONG_T : cnt + 1'b1;
        else
            nxt = (cnt == STRONG_NT) ? STRONG_NT : cnt - 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/bp_cache.sv
// Direct-mapped predictor store: two combinational read ports, one synchronous write port.
// A write to an occupied index replaces the resident tag (eviction).
module bp_cache
    import bp_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned LINES  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    output logic              hit0,
    output cnt_t              dout0,
    input  logic [AWIDTH-1:0] ra1,
    output logic              hit1,
    output cnt_t              dout1,
    input  logic              we,
    input  logic [AWIDTH-1:0] wa,
    input  cnt_t              din
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = AWIDTH - IW;

    logic          vld [LINES];
    logic [TW-1:0] tag [LINES];
    cnt_t          cnt [LINES];

    logic [IW-1:0] idx0, idx1, widx;

    assign idx0 = ra0[IW-1:0];
    assign idx1 = ra1[IW-1:0];
    assign widx = wa[IW-1:0];

    assign hit0  = vld[idx0] && (tag[idx0] == ra0[AWIDTH-1:IW]);
    assign dout0 = cnt[idx0];
    assign hit1  = vld[idx1] && (tag[idx1] == ra1[AWIDTH-1:IW]);
    assign dout1 = cnt[idx1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                vld[i] <= 1'b0;
                tag[i] <= '0;
                cnt[i] <= STRONG_NT;
            end
        end else if (we) begin
            vld[widx] <= 1'b1;
            tag[widx] <= wa[AWIDTH-1:IW];
            cnt[widx] <= din;
        end
    end

endmodule

// File: rtl/bp_update_fifo.sv
// Registered FIFO for branch-resolution updates; head is visible the cycle after push.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter type         entry_t = bp_pkg::entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty,
    output logic   single
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign single  = (count == (PW+1)'(1));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_ctrl.sv
// Branch-predictor controller: zero-latency guesses, buffered read-modify-write updates.
// Optional BP_CTRL_STATS_EN adds update / mispredict counters.
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned LINES  = 128,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] guess_pc,
    output logic              guess_taken,
    output logic              guess_hit,
    input  logic              check_valid,
    input  logic [AWIDTH-1:0] check_pc,
    input  logic              check_taken,
    output logic              check_ready
`ifdef BP_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts
`endif
);

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic              taken;
    } upd_t;

    state_t            state, state_next;
    upd_t              push_entry, head;
    logic              full, empty, single, push_acc, pop;
    logic              hit0, hit1, we;
    cnt_t              dout0, dout1, din, lat_cnt;
    logic [AWIDTH-1:0] ra1, wa, lat_pc;

    assign guess_hit   = hit0;
    assign guess_taken = hit0 && (dout0 >= WEAK_T);

    assign check_ready = !full;
    assign push_acc    = check_valid && !full;
    assign push_entry  = '{pc: check_pc, taken: check_taken};

    assign ra1 = head.pc;
    assign wa  = lat_pc;
    assign din = lat_cnt;

    bp_update_fifo #(
        .entry_t (upd_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (check_valid),
        .din    (push_entry),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .single (single)
    );

    bp_cache #(
        .AWIDTH (AWIDTH),
        .LINES  (LINES)
    ) u_cache (
        .clk   (clk),
        .reset (reset),
        .ra0   (guess_pc),
        .hit0  (hit0),
        .dout0 (dout0),
        .ra1   (ra1),
        .hit1  (hit1),
        .dout1 (dout1),
        .we    (we),
        .wa    (wa),
        .din   (din)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Leaving WRITE goes straight to LOOKUP if anything survives the pop, including a same-cycle push.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty)
                    state_next = LOOKUP;
            end
            LOOKUP: begin
                state_next = WRITE;
            end
            WRITE: begin
                we         = 1'b1;
                pop        = 1'b1;
                state_next = (single && !push_acc) ? IDLE : LOOKUP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_pc  <= '0;
            lat_cnt <= STRONG_NT;
        end else if (state == LOOKUP) begin
            lat_pc  <= head.pc;
            lat_cnt <= sat_update(hit1, dout1, head.taken);
        end
    end

`ifdef BP_CTRL_STATS_EN
    logic lat_misp;

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_misp         <= 1'b0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (state == LOOKUP)
                lat_misp <= (hit1 && (dout1 >= WEAK_T)) != head.taken;
            if (state == WRITE) begin
                stat_updates <= stat_updates + 1'b1;
                if (lat_misp)
                    stat_mispredicts <= stat_mispredicts + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_ctrl.sv
// Self-checking bench for bp_ctrl against a table-based predictor model.
module tb_bp_ctrl;
    import bp_pkg::*;

    localparam int AW = 32;
    localparam int LN = 128;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] guess_pc;
    logic          guess_taken, guess_hit;
    logic          check_valid;
    logic [AW-1:0] check_pc;
    logic          check_taken;
    logic          check_ready;
`ifdef BP_CTRL_STATS_EN
    logic [31:0]   stat_updates, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    bp_ctrl #(.AWIDTH(AW), .LINES(LN), .DEPTH(DP)) dut (
        .clk         (clk),
        .reset       (reset),
        .guess_pc    (guess_pc),
        .guess_taken (guess_taken),
        .guess_hit   (guess_hit),
        .check_valid (check_valid),
        .check_pc    (check_pc),
        .check_taken (check_taken),
        .check_ready (check_ready)
`ifdef BP_CTRL_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference predictor: one slot per index holding the full PC and counter value 0..3.
    bit          m_valid [LN];
    logic [31:0] m_pc    [LN];
    int          m_cnt   [LN];
    int          m_updates, m_misp;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  obs_cyc[$];
    int  cyc = 0;
    bit  saw_not_ready;

    logic [31:0] pool [5] = '{32'h0000_0007, 32'h1111_0007, 32'h0000_0020,
                              32'h0000_0085, 32'h0000_0105};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset && dut.we) begin
            obs_q.push_back('{dut.wa, int'(dut.din)});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LN; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = '0;
            m_cnt[i]   = 0;
        end
        m_updates = 0;
        m_misp    = 0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [31:0] pc, input logic taken);
        int idx;
        bit hit;
        int c;
        idx = int'(pc % LN);
        hit = m_valid[idx] && (m_pc[idx] == pc);
        c   = m_cnt[idx];
        if (hit && ((c >= 2) != taken))
            m_misp++;
        if (!hit)
            c = taken ? 2 : 1;
        else if (taken)
            c = (c == 3) ? 3 : c + 1;
        else
            c = (c == 0) ? 0 : c - 1;
        m_valid[idx] = 1'b1;
        m_pc[idx]    = pc;
        m_cnt[idx]   = c;
        m_updates++;
        exp_q.push_back('{pc, c});
    endtask

    task automatic gchk(input logic [31:0] pc);
        int idx;
        bit hit;
        guess_pc = pc;
        #1;
        idx = int'(pc % LN);
        hit = m_valid[idx] && (m_pc[idx] == pc);
        chk($sformatf("guess_hit[%0h]", pc), guess_hit, hit);
        chk($sformatf("guess_taken[%0h]", pc), guess_taken, hit && (m_cnt[idx] >= 2));
    endtask

    task automatic stats_chk();
`ifdef BP_CTRL_STATS_EN
        chk("stat_updates", stat_updates, m_updates);
        chk("stat_mispredicts", stat_mispredicts, m_misp);
`endif
    endtask

    // Called just after a negedge; leaves check_valid high after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic taken);
        int n = 0;
        check_valid = 1'b1;
        check_pc    = pc;
        check_taken = taken;
        while (!check_ready && n < 50) begin
            saw_not_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("send_timeout", n < 50, 1);
        @(posedge clk);
        model_apply(pc, taken);
        @(negedge clk);
    endtask

    task automatic idle();
        check_valid = 1'b0;
    endtask

    task automatic drain(input bit spacing);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 200, 1);
        @(negedge clk);
        chk("write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("write_pc[%0d]", i), obs_q[i].pc, exp_q[i].pc);
            chk($sformatf("write_cnt[%0d]", i), obs_q[i].cnt, exp_q[i].cnt);
        end
        if (spacing)
            for (int i = 1; i < obs_cyc.size(); i++)
                chk($sformatf("write_gap[%0d]", i), obs_cyc[i] - obs_cyc[i-1], 2);
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        check_valid = 1'b1;
        check_pc    = 32'h0000_0055;
        check_taken = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        check_valid = 1'b0;
        obs_q.delete();
        obs_cyc.delete();
        model_clear();
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        guess_pc    = '0;
        check_valid = 1'b0;
        check_pc    = '0;
        check_taken = 1'b0;
        model_clear();
        do_reset();

        // Post-reset state; the PC presented during reset must never be written.
        chk("ready_after_reset", check_ready, 1);
        gchk(32'h7);
        repeat (10) @(negedge clk);
        chk("no_write_from_reset_push", obs_q.size(), 0);
        gchk(32'h55);
        stats_chk();

        // Counter walk on one PC, including saturation and decay.
        send(32'h7, 1'b1); idle(); drain(0); gchk(32'h7);
        send(32'h7, 1'b1); idle(); drain(0); gchk(32'h7);
        send(32'h7, 1'b1); idle(); drain(0); gchk(32'h7);
        send(32'h7, 1'b0); idle(); drain(0); gchk(32'h7);
        send(32'h7, 1'b0); idle(); drain(0); gchk(32'h7);
        chk("taken_after_decay", guess_taken, 0);
        stats_chk();

        // Same-index conflict evicts the previous tag.
        send(32'h1111_0007, 1'b1); idle(); drain(0);
        gchk(32'h7);
        gchk(32'h1111_0007);
        send(32'h0000_0007, 1'b0); idle(); drain(0);
        gchk(32'h1111_0007);
        gchk(32'h7);

        // Back-pressure: hold check_valid over DEPTH+2 distinct PCs.
        saw_not_ready = 1'b0;
        for (int i = 0; i < DP + 2; i++)
            send(32'h400 + i, i[0]);
        idle();
        chk("ready_dropped", saw_not_ready, 1);
        drain(1);
        for (int i = 0; i < DP + 2; i++)
            gchk(32'h400 + i);
        stats_chk();

        // Back-to-back same-PC updates queued together.
        send(32'h20, 1'b1);
        send(32'h20, 1'b1);
        send(32'h20, 1'b0);
        idle();
        drain(1);
        gchk(32'h20);

        // Randomized traffic over a small PC pool with index aliasing.
        for (int k = 0; k < 120; k++) begin
            bit v;
            bit acc;
            v           = ($urandom_range(0, 2) != 0);
            check_valid = v;
            check_pc    = pool[$urandom_range(0, 4)];
            check_taken = $urandom_range(0, 1) == 1;
            acc         = v && check_ready;
            @(posedge clk);
            if (acc)
                model_apply(check_pc, check_taken);
            @(negedge clk);
        end
        idle();
        drain(0);
        for (int i = 0; i < 5; i++)
            gchk(pool[i]);
        stats_chk();

        // Reset while an update is in LOOKUP with entries still queued.
        send(32'h300, 1'b1);
        send(32'h301, 1'b1);
        send(32'h302, 1'b1);
        send(32'h303, 1'b1);
        idle();
        n = 0;
        while (dut.state !== LOOKUP && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_lookup", n < 20, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        obs_cyc.delete();
        model_clear();
        chk("ready_after_abort", check_ready, 1);
        repeat (20) @(negedge clk);
        chk("no_write_after_abort", obs_q.size(), 0);
        for (int i = 0; i < 4; i++)
            gchk(32'h300 + i);
        gchk(32'h7);
        stats_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
